// File: rtl/get_deser_pkg.sv
// Shared types and constants for the get_deser serial-frame reader.
package get_deser_pkg;

    // Default payload width of a frame.
    localparam int DEF_DATA_W = 8;

    // Width of the payload bit counter at the default payload width.
    localparam int CNT_W = $clog2(DEF_DATA_W) + 1;

    // Resumption tag encoding for the reactive step machine.
    typedef enum logic [1:0] {
        TAG_IDLE = 2'd0,
        TAG_DATA = 2'd1,
        TAG_STOP = 2'd2,
        TAG_WAIT = 2'd3
    } tag_e;

    // Counter width needed to count DATA_W payload bits for any width.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/get_deser_if.sv
// Serial-in / parallel-out bundle between a line driver and get_deser.
interface get_deser_if import get_deser_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic              __in0;
    logic [DATA_W-1:0] __out0;
    logic              __out1;
    logic              __out2;

    // The line driver owns the serial bit and observes the decoded word.
    modport master (output __in0, input __out0, input __out1, input __out2);
    // The reader consumes the serial bit and produces the decoded word.
    modport slave  (input __in0, output __out0, output __out1, output __out2);
endinterface

// File: rtl/get_deser_shift.sv
// Right-shifting payload register: new line bits enter at the MSB so that,
// after DATA_W shifts, bit 0 holds the first (least significant) payload bit.
module get_deser_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] shift_r;

    generate
        if (DATA_W == 1) begin : g_one
            // Single-bit payload: the register simply captures the line bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_r <= 1'b0;
                end else if (en) begin
                    shift_r <= din;
                end else begin
                    shift_r <= shift_r;
                end
            end
        end else begin : g_multi
            // Shift the line bit in at the MSB end, dropping the LSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_r <= {DATA_W{1'b0}};
                end else if (en) begin
                    shift_r <= {din, shift_r[DATA_W-1:1]};
                end else begin
                    shift_r <= shift_r;
                end
            end
        end
    endgenerate

    assign q = shift_r;

endmodule

// File: rtl/get_deser.sv
// Reactive serial-frame reader: start bit 1, DATA_W payload bits LSB first,
// stop bit 0. A good frame produces a one-cycle valid pulse with the word;
// a bad stop bit produces a one-cycle error pulse and the reader waits for
// the line to return to 0 before hunting for the next start bit.
module get_deser import get_deser_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    get_deser_if.slave  bus
);

    localparam int CW = cnt_width(DATA_W);

    localparam logic [1:0] IDLE = 2'(TAG_IDLE);
    localparam logic [1:0] DATA = 2'(TAG_DATA);
    localparam logic [1:0] STOP = 2'(TAG_STOP);
    localparam logic [1:0] WAIT = 2'(TAG_WAIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    logic [1:0]        tag_r;
    logic [1:0]        tag_nx_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nx_s;
    logic              shift_en_s;
    logic [DATA_W-1:0] shift_q_s;
    logic [DATA_W-1:0] out0_r;
    logic [DATA_W-1:0] out0_nx_s;
    logic              out1_r;
    logic              out1_nx_s;
    logic              out2_r;
    logic              out2_nx_s;

    get_deser_shift #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .rst_n (rst),
        .en    (shift_en_s),
        .din   (bus.__in0),
        .q     (shift_q_s)
    );

    // One reactive step: next tag, counter, shift enable and output values.
    always_comb begin
        tag_nx_s   = tag_r;
        cnt_nx_s   = cnt_r;
        shift_en_s = 1'b0;
        out0_nx_s  = out0_r;
        out1_nx_s  = 1'b0;
        out2_nx_s  = 1'b0;
        case (tag_r)
            IDLE: begin
                if (bus.__in0) begin
                    tag_nx_s = DATA;
                    cnt_nx_s = {CW{1'b0}};
                end else begin
                    tag_nx_s = IDLE;
                end
            end
            DATA: begin
                shift_en_s = 1'b1;
                cnt_nx_s   = cnt_r + CW'(1);
                if (cnt_r == CNT_LAST) begin
                    tag_nx_s = STOP;
                end else begin
                    tag_nx_s = DATA;
                end
            end
            STOP: begin
                if (!bus.__in0) begin
                    out0_nx_s = shift_q_s;
                    out1_nx_s = 1'b1;
                    tag_nx_s  = IDLE;
                end else begin
                    out2_nx_s = 1'b1;
                    tag_nx_s  = WAIT;
                end
            end
            WAIT: begin
                // A 1 here is the tail of a broken frame, never a start bit.
                if (!bus.__in0) begin
                    tag_nx_s = IDLE;
                end else begin
                    tag_nx_s = WAIT;
                end
            end
            default: begin
                tag_nx_s = IDLE;
                cnt_nx_s = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r  <= IDLE;
            cnt_r  <= {CW{1'b0}};
            out0_r <= {DATA_W{1'b0}};
            out1_r <= 1'b0;
            out2_r <= 1'b0;
        end else begin
            tag_r  <= tag_nx_s;
            cnt_r  <= cnt_nx_s;
            out0_r <= out0_nx_s;
            out1_r <= out1_nx_s;
            out2_r <= out2_nx_s;
        end
    end

    assign bus.__out0 = out0_r;
    assign bus.__out1 = out1_r;
    assign bus.__out2 = out2_r;

endmodule

// File: tb/tb_get_deser.sv
// Directed bench for get_deser: idle line, single frame, back-to-back
// frames, framing error with recovery, and reset in the middle of a frame.
module tb_get_deser;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    get_deser_if #(.DATA_W(8)) bus ();

    get_deser #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one line bit, let one rising edge consume it, sample just after.
    task automatic step(input logic b);
        bus.__in0 = b;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // Start bit, eight payload bits LSB first, then the given stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        step(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(d[i]);
        end
        step(stop_bit);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.__in0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (bus.__out0 !== 8'h00 || bus.__out1 !== 1'b0 || bus.__out2 !== 1'b0) begin
            $display("FAIL reset_outputs got out0=%h out1=%b out2=%b want 00 0 0",
                     bus.__out0, bus.__out1, bus.__out2);
            errors = errors + 1;
        end
        rst = 1'b1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (bus.__out0 !== 8'h00 || bus.__out1 !== 1'b0 || bus.__out2 !== 1'b0) begin
                bad = bad + 1;
            end
        end
        checks = checks + 1;
        if (bad !== 0) begin
            $display("FAIL idle_quiet got %0d noisy cycles want 0", bad);
            errors = errors + 1;
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b1 || bus.__out2 !== 1'b0) begin
            $display("FAIL single_pulse got out1=%b out2=%b want 1 0", bus.__out1, bus.__out2);
            errors = errors + 1;
        end
        checks = checks + 1;
        if (bus.__out0 !== 8'hA5) begin
            $display("FAIL single_data got %h want a5", bus.__out0);
            errors = errors + 1;
        end
        step(1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b0 || bus.__out0 !== 8'hA5) begin
            $display("FAIL single_after got out1=%b out0=%h want 0 a5", bus.__out1, bus.__out0);
            errors = errors + 1;
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        send_frame(8'h3C, 1'b0);
        first_cyc = cyc;
        checks = checks + 1;
        if (bus.__out1 !== 1'b1 || bus.__out0 !== 8'h3C) begin
            $display("FAIL b2b_first got out1=%b out0=%h want 1 3c", bus.__out1, bus.__out0);
            errors = errors + 1;
        end
        step(1'b1);
        checks = checks + 1;
        if (bus.__out1 !== 1'b0 || bus.__out0 !== 8'h3C) begin
            $display("FAIL b2b_gap got out1=%b out0=%h want 0 3c", bus.__out1, bus.__out0);
            errors = errors + 1;
        end
        for (int i = 0; i < 8; i++) begin
            step(((8'hC3 >> i) & 8'h01) != 8'h00);
        end
        step(1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b1 || bus.__out0 !== 8'hC3 || (cyc - first_cyc) !== 10) begin
            $display("FAIL b2b_second got out1=%b out0=%h dist=%0d want 1 c3 10",
                     bus.__out1, bus.__out0, cyc - first_cyc);
            errors = errors + 1;
        end
        step(1'b0);
    endtask

    task automatic test_frame_error();
        int bad;
        send_frame(8'h0F, 1'b1);
        checks = checks + 1;
        if (bus.__out2 !== 1'b1 || bus.__out1 !== 1'b0 || bus.__out0 !== 8'hC3) begin
            $display("FAIL ferr_pulse got out2=%b out1=%b out0=%h want 1 0 c3",
                     bus.__out2, bus.__out1, bus.__out0);
            errors = errors + 1;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            if (bus.__out2 !== 1'b0 || bus.__out1 !== 1'b0 || bus.__out0 !== 8'hC3) begin
                bad = bad + 1;
            end
        end
        step(1'b0);
        if (bus.__out2 !== 1'b0 || bus.__out1 !== 1'b0 || bus.__out0 !== 8'hC3) begin
            bad = bad + 1;
        end
        checks = checks + 1;
        if (bad !== 0) begin
            $display("FAIL ferr_wait got %0d bad cycles want 0", bad);
            errors = errors + 1;
        end
    endtask

    task automatic test_recovery();
        send_frame(8'h55, 1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b1 || bus.__out2 !== 1'b0 || bus.__out0 !== 8'h55) begin
            $display("FAIL recover got out1=%b out2=%b out0=%h want 1 0 55",
                     bus.__out1, bus.__out2, bus.__out0);
            errors = errors + 1;
        end
        step(1'b0);
    endtask

    task automatic test_reset_mid();
        int bad;
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
        end
        #2;
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (bus.__out0 !== 8'h00 || bus.__out1 !== 1'b0 || bus.__out2 !== 1'b0) begin
            $display("FAIL rstmid_async got out0=%h out1=%b out2=%b want 00 0 0",
                     bus.__out0, bus.__out1, bus.__out2);
            errors = errors + 1;
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(i[0]);
            if (bus.__out0 !== 8'h00 || bus.__out1 !== 1'b0 || bus.__out2 !== 1'b0) begin
                bad = bad + 1;
            end
        end
        checks = checks + 1;
        if (bad !== 0) begin
            $display("FAIL rstmid_hold got %0d bad cycles want 0", bad);
            errors = errors + 1;
        end
        bus.__in0 = 1'b0;
        #2;
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        checks = checks + 1;
        if (bus.__out0 !== 8'h00 || bus.__out1 !== 1'b0 || bus.__out2 !== 1'b0) begin
            $display("FAIL rstmid_release got out0=%h out1=%b out2=%b want 00 0 0",
                     bus.__out0, bus.__out1, bus.__out2);
            errors = errors + 1;
        end
        send_frame(8'h81, 1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b1 || bus.__out2 !== 1'b0 || bus.__out0 !== 8'h81) begin
            $display("FAIL rstmid_next got out1=%b out2=%b out0=%h want 1 0 81",
                     bus.__out1, bus.__out2, bus.__out0);
            errors = errors + 1;
        end
        step(1'b0);
        checks = checks + 1;
        if (bus.__out1 !== 1'b0 || bus.__out0 !== 8'h81) begin
            $display("FAIL rstmid_after got out1=%b out0=%h want 0 81", bus.__out1, bus.__out0);
            errors = errors + 1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst = 1'b0;
        bus.__in0 = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_recovery();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
